rv32_cpu_wb_ctrl: RTL and testbench
===================================

Name: rv32_cpu_wb_ctrl

Overview:
- Write-back controller: the producer side of the CPU register-file write port.
- Accepts retiring results from execute, tracks up to LQ_DEPTH outstanding loads in order, and aligns/sign-extends returning load data.
- Drives the register file's write-back select, enable, destination and source buses.
- Keeps a busy scoreboard so decode can stall on read-after-load hazards.

Parameters:
- XLEN, 32, data width.
- RVE, 1, 1 = 16 architectural registers (rd/rs bit 4 ignored), 0 = 32.
- LQ_DEPTH, 2, outstanding-load queue depth; power of 2, at least 2.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_iss_valid  in  1  execute presents a retiring instruction.
- o_iss_ready  out  1  controller accepts it; transfer when valid & ready.
- i_iss_sel  in  2  source: 00 ALU, 01 MEM (load), 10 CSR, 11 NPC.
- i_iss_rd  in  5  destination register.
- i_iss_funct3  in  3  load size/sign (MEM only).
- i_iss_addr_lo  in  2  load byte offset (MEM only).
- i_alu, i_csr, i_npc  in  XLEN each  result buses.
- i_mem_rvalid  in  1  in-order load response strobe.
- i_mem_rdata  in  32  raw aligned-word read data.
- i_mem_err  in  1  bus error qualifying i_mem_rvalid.
- i_chk_rs1, i_chk_rs2  in  5 each  decode source registers to check.
- o_hazard  out  1  a checked register has a pending load.
- o_wb_en  out  1  register-file write enable.
- o_wb_sel  out  2  register-file source select.
- o_wb_rd  out  5  register-file destination.
- o_wb_alu, o_wb_mem, o_wb_csr, o_wb_npc  out  XLEN each  registered source buses.
- o_load_err  out  1  one-cycle pulse on load bus error.
- o_lq_busy  out  1  load queue non-empty.

Behaviour:
- Reset (i_rstn low, asynchronous):
  - all outputs 0; load queue empty; busy[] all 0.
  - Outstanding loads are discarded; responses arriving after reset with an empty queue are ignored.
- o_iss_ready = !i_mem_rvalid & !(busy[i_iss_rd] & i_iss_rd!=0) & !(i_iss_sel==MEM & lq_full).
  - Combinational; i_iss_valid must not depend on o_iss_ready.
- Non-load transfer:
  - Next cycle: o_wb_en = (rd!=0), o_wb_sel = sel, o_wb_rd = rd.
  - The matching source bus is registered; the other buses hold their previous value.
  - Latency is exactly 1 cycle.
- Load transfer:
  - Push {rd, funct3, addr_lo} into the FIFO; set busy[rd] if rd!=0.
  - No write-back that cycle; the next cycle's o_wb_en is 0 unless something else writes.
- Response (i_mem_rvalid, queue non-empty):
  - Pop the head.
  - If !i_mem_err: shift i_mem_rdata right by 8*addr_lo, then extend per funct3:
    - 000 LB sign-extend, 001 LH sign-extend, 010 LW.
    - 100 LBU zero-extend, 101 LHU zero-extend.
    - Any other code is treated as LW.
    - Next cycle: o_wb_en = (rd!=0), o_wb_sel = 01, o_wb_mem = result.
  - If i_mem_err: no write-back; o_load_err pulses next cycle.
  - busy[rd] is cleared on the edge that ends the write-back cycle (the same edge the register file commits), i.e. 2 edges after the response.
  - On error, busy[rd] is cleared 1 edge after the response.
- Response with empty queue: ignored; no write, no error pulse.
- Simultaneous response and issue:
  - The response owns the write port; o_iss_ready is forced low.
  - Push and pop therefore never coincide.
- FIFO: read/write pointers are log2(LQ_DEPTH)+1 bits wide, wrapping modulo 2*LQ_DEPTH. Full = MSBs differ and lower bits equal.
- o_hazard = (busy[rs1] & rs1!=0) | (busy[rs2] & rs2!=0); combinational.
- o_lq_busy = !empty.
- RVE=1: only index bits [3:0] are used for busy[] and the zero test.

Optional Feature:
- Macro: RV32_WB_FWD_EN
- Defined:
  - busy[rd] clears on the response edge itself.
  - During a write-back cycle, o_hazard ignores a source equal to o_wb_rd, because decode bypasses from o_wb_* (one cycle earlier release).
- Undefined: timing exactly as in Behaviour; no bypass assumption.

Test Plan:
- ALU issue rd=5, i_alu=0x12345678 -> next cycle o_wb_en=1, o_wb_sel=00, o_wb_rd=5, o_wb_alu=0x12345678; following cycle o_wb_en=0.
- LB rd=3, addr_lo=2, response rdata=0x00800000 -> o_wb_mem=0xFFFFFF80; LBU same data -> 0x00000080; LH addr_lo=2, rdata=0x80010000 -> 0xFFFF8001.
- Two loads (rd=1, rd=2) issued, third load attempted -> o_iss_ready=0 while queue is full; responses write rd=1 then rd=2 in order; o_lq_busy drops after the second pop.
- Load rd=4 pending, i_chk_rs1=4 -> o_hazard=1 until 2 edges after the response (1 edge with RV32_WB_FWD_EN); ALU issue to rd=4 is stalled meanwhile.
- Response with i_mem_err=1 for rd=6 -> no o_wb_en, o_load_err pulses once, busy[6] cleared; ALU issue rd=0 -> o_wb_en stays 0.
- i_rstn low with 2 loads pending -> o_lq_busy=0 and o_hazard=0 immediately; a later stray i_mem_rvalid produces no write.

Source files
------------

// File: rtl/rv32_cpu_wb_ctrl_if.sv
// Issue and load-response channel of the rv32 write-back controller.
// The master is the execute/memory side; the slave is the controller.
interface rv32_cpu_wb_ctrl_if #(
    parameter int XLEN = 32
);
    logic            iss_valid;
    logic            iss_ready;
    logic [1:0]      iss_sel;
    logic [4:0]      iss_rd;
    logic [2:0]      iss_funct3;
    logic [1:0]      iss_addr_lo;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] csr;
    logic [XLEN-1:0] npc;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            mem_err;

    modport master (
        output iss_valid, iss_sel, iss_rd, iss_funct3, iss_addr_lo,
        output alu, csr, npc, mem_rvalid, mem_rdata, mem_err,
        input  iss_ready
    );

    modport slave (
        input  iss_valid, iss_sel, iss_rd, iss_funct3, iss_addr_lo,
        input  alu, csr, npc, mem_rvalid, mem_rdata, mem_err,
        output iss_ready
    );
endinterface

// File: rtl/rv32_cpu_wb_ctrl.sv
// rv32 write-back controller: retires execute results into the register
// file write port, tracks outstanding loads in order, aligns/extends load
// data and keeps a busy scoreboard for decode hazard stalls.
// Optional macro RV32_WB_FWD_EN: release busy[] on the response edge and
// mask hazards against the register currently being written back.
module rv32_cpu_wb_ctrl #(
    parameter int XLEN     = 32,
    parameter int RVE      = 1,
    parameter int LQ_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    rv32_cpu_wb_ctrl_if.slave   bus,
    input  logic [4:0]          i_chk_rs1,
    input  logic [4:0]          i_chk_rs2,
    output logic                o_hazard,
    output logic                o_wb_en,
    output logic [1:0]          o_wb_sel,
    output logic [4:0]          o_wb_rd,
    output logic [XLEN-1:0]     o_wb_alu,
    output logic [XLEN-1:0]     o_wb_mem,
    output logic [XLEN-1:0]     o_wb_csr,
    output logic [XLEN-1:0]     o_wb_npc,
    output logic                o_load_err,
    output logic                o_lq_busy
);
    localparam int AW = $clog2(LQ_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_CSR = 2'b10,
        SEL_NPC = 2'b11
    } sel_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lq_entry_t;

    // Scoreboard index: with RVE only 16 registers exist, bit 4 is dropped.
    function automatic logic [4:0] reg_idx(input logic [4:0] r);
        return (RVE != 0) ? {1'b0, r[3:0]} : r;
    endfunction

    function automatic logic reg_nz(input logic [4:0] r);
        return reg_idx(r) != 5'd0;
    endfunction

    lq_entry_t       lq_mem [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            lq_empty;
    logic            lq_full;
    lq_entry_t       head;
    logic [31:0]     busy;
    logic            fire;
    logic            push;
    logic            pop;
    logic [31:0]     shifted;
    logic [XLEN-1:0] load_data;
    logic            haz1;
    logic            haz2;
`ifndef RV32_WB_FWD_EN
    logic            clr_pend;
    logic [4:0]      clr_idx;
`endif

    assign lq_empty  = (wr_ptr == rd_ptr);
    assign lq_full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head      = lq_mem[rd_ptr[AW-1:0]];
    assign o_lq_busy = !lq_empty;

    // A response always owns the write port, so issue stalls whenever one arrives.
    assign bus.iss_ready = !bus.mem_rvalid
                         && !(busy[reg_idx(bus.iss_rd)] && reg_nz(bus.iss_rd))
                         && !((sel_e'(bus.iss_sel) == SEL_MEM) && lq_full);

    assign fire = bus.iss_valid && bus.iss_ready;
    assign push = fire && (sel_e'(bus.iss_sel) == SEL_MEM);
    assign pop  = bus.mem_rvalid && !lq_empty;

    // Load alignment and extension of the popped response.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shifted   = bus.mem_rdata >> {head.addr_lo, 3'b000};
        load_data = XLEN'($signed(shifted));
        case (head.funct3)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            default: load_data = XLEN'($signed(shifted));
        endcase
    end

    // Hazard when a checked source has a pending load.
    always_comb begin
        haz1 = busy[reg_idx(i_chk_rs1)] && reg_nz(i_chk_rs1);
        haz2 = busy[reg_idx(i_chk_rs2)] && reg_nz(i_chk_rs2);
`ifdef RV32_WB_FWD_EN
        if (o_wb_en && (reg_idx(i_chk_rs1) == reg_idx(o_wb_rd))) haz1 = 1'b0;
        if (o_wb_en && (reg_idx(i_chk_rs2) == reg_idx(o_wb_rd))) haz2 = 1'b0;
`endif
        o_hazard = haz1 || haz2;
    end

    // Load queue storage.
    // NOTE: payload storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) lq_mem[wr_ptr[AW-1:0]] <= '{rd: bus.iss_rd, funct3: bus.iss_funct3,
                                             addr_lo: bus.iss_addr_lo};
    end

    // Load queue pointers; wrap naturally modulo 2*LQ_DEPTH.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write-back port registers: a load response takes priority over issue.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wb_en    <= 1'b0;
            o_wb_sel   <= 2'b00;
            o_wb_rd    <= 5'd0;
            o_wb_alu   <= '0;
            o_wb_mem   <= '0;
            o_wb_csr   <= '0;
            o_wb_npc   <= '0;
            o_load_err <= 1'b0;
        end else begin
            o_wb_en    <= 1'b0;
            o_load_err <= 1'b0;
            if (pop) begin
                if (bus.mem_err) begin
                    o_load_err <= 1'b1;
                end else begin
                    o_wb_en  <= reg_nz(head.rd);
                    o_wb_sel <= SEL_MEM;
                    o_wb_rd  <= head.rd;
                    o_wb_mem <= load_data;
                end
            end else if (fire && !push) begin
                o_wb_en  <= reg_nz(bus.iss_rd);
                o_wb_sel <= bus.iss_sel;
                o_wb_rd  <= bus.iss_rd;
                case (sel_e'(bus.iss_sel))
                    SEL_CSR: o_wb_csr <= bus.csr;
                    SEL_NPC: o_wb_npc <= bus.npc;
                    default: o_wb_alu <= bus.alu;
                endcase
            end
        end
    end

    // Busy scoreboard: set on load push, cleared when the load's write-back commits.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy     <= '0;
`ifndef RV32_WB_FWD_EN
            clr_pend <= 1'b0;
            clr_idx  <= 5'd0;
`endif
        end else begin
`ifdef RV32_WB_FWD_EN
            if (pop) busy[reg_idx(head.rd)] <= 1'b0;
`else
            clr_pend <= 1'b0;
            if (clr_pend) busy[clr_idx] <= 1'b0;
            if (pop) begin
                if (bus.mem_err) begin
                    busy[reg_idx(head.rd)] <= 1'b0;
                end else begin
                    clr_pend <= 1'b1;
                    clr_idx  <= reg_idx(head.rd);
                end
            end
`endif
            if (push && reg_nz(bus.iss_rd)) busy[reg_idx(bus.iss_rd)] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rv32_cpu_wb_ctrl.sv
// Directed self-checking bench for rv32_cpu_wb_ctrl (default parameters).
module tb_rv32_cpu_wb_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [4:0]  i_chk_rs1 = 5'd0;
    logic [4:0]  i_chk_rs2 = 5'd0;
    logic        o_hazard;
    logic        o_wb_en;
    logic [1:0]  o_wb_sel;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_alu;
    logic [31:0] o_wb_mem;
    logic [31:0] o_wb_csr;
    logic [31:0] o_wb_npc;
    logic        o_load_err;
    logic        o_lq_busy;
    int          checks = 0;
    int          failures = 0;

    rv32_cpu_wb_ctrl_if #(.XLEN(32)) bus ();

    rv32_cpu_wb_ctrl dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .bus        (bus),
        .i_chk_rs1  (i_chk_rs1),
        .i_chk_rs2  (i_chk_rs2),
        .o_hazard   (o_hazard),
        .o_wb_en    (o_wb_en),
        .o_wb_sel   (o_wb_sel),
        .o_wb_rd    (o_wb_rd),
        .o_wb_alu   (o_wb_alu),
        .o_wb_mem   (o_wb_mem),
        .o_wb_csr   (o_wb_csr),
        .o_wb_npc   (o_wb_npc),
        .o_load_err (o_load_err),
        .o_lq_busy  (o_lq_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] lo);
        bus.iss_valid   = 1'b1;
        bus.iss_sel     = sel;
        bus.iss_rd      = rd;
        bus.iss_funct3  = f3;
        bus.iss_addr_lo = lo;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        bus.mem_err    = err;
    endtask

    // Issue one load, then deliver its response; returns just after the response edge.
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] data);
        issue(2'b01, rd, f3, lo);
        tick();
        bus.iss_valid = 1'b0;
        respond(data, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        bus.iss_valid = 1'b0; bus.iss_sel = 2'b00; bus.iss_rd = 5'd0;
        bus.iss_funct3 = 3'd0; bus.iss_addr_lo = 2'd0;
        bus.alu = '0; bus.csr = '0; bus.npc = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;

        // Reset state
        #12;
        check("rst_wb_en", 32'(o_wb_en), 32'd0);
        check("rst_lq_busy", 32'(o_lq_busy), 32'd0);
        check("rst_load_err", 32'(o_load_err), 32'd0);
        check("rst_wb_alu", o_wb_alu, 32'd0);
        tick();
        i_rstn = 1'b1;

        // ALU write-back, 1-cycle latency
        bus.alu = 32'h12345678;
        issue(2'b00, 5'd5, 3'd0, 2'd0);
        #1 check("alu_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        check("alu_wb_en", 32'(o_wb_en), 32'd1);
        check("alu_wb_sel", 32'(o_wb_sel), 32'd0);
        check("alu_wb_rd", 32'(o_wb_rd), 32'd5);
        check("alu_wb_alu", o_wb_alu, 32'h12345678);
        tick();
        check("alu_wb_en_drop", 32'(o_wb_en), 32'd0);

        // Load push: no write-back that cycle, queue busy
        issue(2'b01, 5'd3, 3'b000, 2'd2);
        tick();
        bus.iss_valid = 1'b0;
        check("lb_push_wb_en", 32'(o_wb_en), 32'd0);
        check("lb_push_lq_busy", 32'(o_lq_busy), 32'd1);
        respond(32'h00800000, 1'b0);
        #1 check("resp_blocks_ready", 32'(bus.iss_ready), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("lb_wb_en", 32'(o_wb_en), 32'd1);
        check("lb_wb_sel", 32'(o_wb_sel), 32'd1);
        check("lb_wb_rd", 32'(o_wb_rd), 32'd3);
        check("lb_wb_mem", o_wb_mem, 32'hFFFFFF80);
        check("lb_lq_empty", 32'(o_lq_busy), 32'd0);
        tick();

        // LBU same data, LH at offset 2
        do_load(5'd3, 3'b100, 2'd2, 32'h00800000);
        check("lbu_wb_mem", o_wb_mem, 32'h00000080);
        tick();
        do_load(5'd3, 3'b001, 2'd2, 32'h80010000);
        check("lh_wb_mem", o_wb_mem, 32'hFFFF8001);
        tick();

        // Queue full: two loads accepted, third stalled, in-order responses
        issue(2'b01, 5'd1, 3'b010, 2'd0);
        tick();
        issue(2'b01, 5'd2, 3'b010, 2'd0);
        tick();
        issue(2'b01, 5'd7, 3'b010, 2'd0);
        #1 check("full_ready", 32'(bus.iss_ready), 32'd0);
        tick();
        bus.iss_valid = 1'b0;
        check("full_lq_busy", 32'(o_lq_busy), 32'd1);
        respond(32'h11223344, 1'b0);
        tick();
        check("pop1_wb_rd", 32'(o_wb_rd), 32'd1);
        check("pop1_wb_mem", o_wb_mem, 32'h11223344);
        check("pop1_lq_busy", 32'(o_lq_busy), 32'd1);
        respond(32'hAABBCCDD, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("pop2_wb_rd", 32'(o_wb_rd), 32'd2);
        check("pop2_wb_mem", o_wb_mem, 32'hAABBCCDD);
        check("pop2_lq_busy", 32'(o_lq_busy), 32'd0);
        tick();
        tick();

        // Read-after-load hazard on rd=4
        issue(2'b01, 5'd4, 3'b010, 2'd0);
        tick();
        bus.iss_valid = 1'b0;
        i_chk_rs1 = 5'd4;
        #1 check("haz_rs1", 32'(o_hazard), 32'd1);
        i_chk_rs1 = 5'd0; i_chk_rs2 = 5'd20;
        #1 check("haz_rs2_rve_alias", 32'(o_hazard), 32'd1);
        i_chk_rs2 = 5'd0; i_chk_rs1 = 5'd4;
        bus.alu = 32'h0000BEEF;
        issue(2'b00, 5'd4, 3'd0, 2'd0);
        #1 check("haz_alu_stall_ready", 32'(bus.iss_ready), 32'd0);
        tick();
        bus.iss_valid = 1'b0;
        check("haz_alu_stall_wb", 32'(o_wb_en), 32'd0);
        respond(32'h00000000, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
`ifdef RV32_WB_FWD_EN
        check("haz_after_resp", 32'(o_hazard), 32'd0);
`else
        check("haz_after_resp", 32'(o_hazard), 32'd1);
`endif
        tick();
        check("haz_released", 32'(o_hazard), 32'd0);
        issue(2'b00, 5'd4, 3'd0, 2'd0);
        #1 check("haz_alu_ready", 32'(bus.iss_ready), 32'd1);
        tick();
        bus.iss_valid = 1'b0;
        check("haz_alu_wb_rd", 32'(o_wb_rd), 32'd4);
        check("haz_alu_wb_alu", o_wb_alu, 32'h0000BEEF);
        i_chk_rs1 = 5'd0;

        // Load bus error on rd=6
        issue(2'b01, 5'd6, 3'b010, 2'd0);
        tick();
        bus.iss_valid = 1'b0;
        respond(32'hDEADBEEF, 1'b1);
        tick();
        bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
        i_chk_rs1 = 5'd6;
        #1;
        check("err_wb_en", 32'(o_wb_en), 32'd0);
        check("err_pulse", 32'(o_load_err), 32'd1);
        check("err_busy_clr", 32'(o_hazard), 32'd0);
        i_chk_rs1 = 5'd0;
        bus.alu = 32'hCAFEF00D;
        issue(2'b00, 5'd0, 3'd0, 2'd0);
        tick();
        bus.iss_valid = 1'b0;
        check("err_pulse_end", 32'(o_load_err), 32'd0);
        check("rd0_wb_en", 32'(o_wb_en), 32'd0);
        check("rd0_wb_alu", o_wb_alu, 32'hCAFEF00D);

        // CSR write-back; ALU bus holds
        bus.csr = 32'h0000ABCD;
        issue(2'b10, 5'd9, 3'd0, 2'd0);
        tick();
        bus.iss_valid = 1'b0;
        check("csr_wb_sel", 32'(o_wb_sel), 32'd2);
        check("csr_wb_csr", o_wb_csr, 32'h0000ABCD);
        check("csr_alu_hold", o_wb_alu, 32'hCAFEF00D);

        // Reset with two loads pending, then a stray response
        issue(2'b01, 5'd10, 3'b010, 2'd0);
        tick();
        issue(2'b01, 5'd11, 3'b010, 2'd0);
        tick();
        bus.iss_valid = 1'b0;
        i_chk_rs1 = 5'd10;
        #1 check("pre_rst_hazard", 32'(o_hazard), 32'd1);
        i_rstn = 1'b0;
        #1;
        check("rst_async_lq_busy", 32'(o_lq_busy), 32'd0);
        check("rst_async_hazard", 32'(o_hazard), 32'd0);
        tick();
        i_rstn = 1'b1;
        respond(32'h55555555, 1'b0);
        tick();
        bus.mem_rvalid = 1'b0;
        check("stray_wb_en", 32'(o_wb_en), 32'd0);
        check("stray_load_err", 32'(o_load_err), 32'd0);
        check("stray_lq_busy", 32'(o_lq_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
